uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Transmit-side buffer that sits directly upstream of the UART transmitter.
- Accepts bytes from the CPU or bus side with a simple write strobe and stores them in a circular FIFO.
- Presents the head byte to the transmitter through its next/ready handshake, one byte per request.
- Clocked on the same divided clock as the transmitter, so no clock-domain crossing is needed.

Parameters:
- DATA, 8: width of one data word in bits; must match the transmitter's DATA.
- DEPTH, 16: number of FIFO entries; must be a power of two, minimum 2.
- ADDR_BITS, $clog2(DEPTH): local; pointer width.
- COUNT_BITS, ADDR_BITS+1: local; occupancy width, holds 0..DEPTH.

Ports:
- i_divided_clk  input  1  clock; the same enable-gated clock that drives the transmitter.
- i_rst  input  1  asynchronous, active-high reset.
- i_en  input  1  read-side enable, tied to the transmitter's i_en; a pop happens only while this is high.
- i_wr_en  input  1  write strobe; 1 pushes i_wr_data.
- i_wr_data  input  DATA  word to push.
- i_next  input  1  transmitter's o_next; transmitter is idle and requesting a word.
- i_clr_ovf  input  1  synchronous clear of o_overflow.
- o_data  output  DATA  head-of-FIFO word (first-word fall-through); connects to transmitter i_data.
- o_ready  output  1  combinational, equal to i_next & ~o_empty; connects to transmitter i_ready.
- o_full  output  1  count == DEPTH.
- o_empty  output  1  count == 0.
- o_count  output  COUNT_BITS  current occupancy.
- o_overflow  output  1  sticky; set when a write is dropped.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - Write and read pointers go to 0, count to 0.
  - o_empty=1, o_full=0, o_overflow=0, o_ready=0.
  - o_data=0: memory is not cleared, so o_data is forced to 0 while empty.
  - Any stored data is discarded.
- Push: accepted on a rising edge when i_wr_en=1 and o_full=0.
  - mem[wr_ptr] <= i_wr_data; wr_ptr increments modulo DEPTH (natural wrap).
- Dropped write: i_wr_en=1 while o_full=1.
  - Data discarded, pointers unchanged, o_overflow <= 1.
  - This holds even if a pop occurs on the same edge; full is evaluated before the edge.
- Pop: occurs on a rising edge when i_en=1, i_next=1 and o_empty=0, i.e. o_ready=1 with i_en=1.
  - rd_ptr increments modulo DEPTH.
  - The transmitter latches o_data on this same edge and drops o_next on the next cycle.
  - o_ready therefore falls after exactly one cycle, giving exactly one pop per request.
- o_ready is gated by i_next so that a word is never offered while the transmitter is not requesting. This prevents a duplicate latch on the transmitter's first IDLE cycle.
- Simultaneous push and pop (not full, not empty):
  - Both pointers advance; count unchanged.
- Push while empty:
  - Word appears on o_data the cycle after the write edge.
  - o_ready can assert in that same cycle if i_next=1; there is no bypass within the write cycle.
- Count:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - o_full and o_empty are registered, derived from the next count.
- o_overflow:
  - Cleared by i_clr_ovf=1 on an edge.
  - If a drop and a clear happen on the same edge, the set wins.
- i_en=0 freezes the read side only; writes continue.
- Latency: write edge to o_data valid is 1 cycle; write edge to transmitter latch is at least 1 cycle, when i_next is already high.

Test Plan:
- Reset, then write 0xA5 with i_next=0 → o_empty 1→0, o_count=1, o_data=0xA5, o_ready=0; raise i_next → o_ready=1; one edge later o_count=0, o_empty=1.
- With i_next held 0, write 0x01..0x10 (16 writes, DEPTH=16) → o_full=1, o_count=16; a 17th write of 0xFF → o_overflow=1, o_count still 16; subsequent pops return 0x01..0x10 in order, 0xFF never appears.
- Drive the FIFO with a transmitter model (o_next=1 in idle, 0 for N cycles after a latch) and write 0x11,0x22,0x33 back-to-back → exactly three pops, transmitter latches 0x11, 0x22, 0x33 with no duplicates; o_empty=1 at the end.
- Wrap-around: push 10 and pop 10 words, then push 12 words 0x40..0x4B and drain → order preserved across pointer wrap, o_count peaks at 12.
- Simultaneous push and pop at o_count=5 → o_count stays 5, popped word is the oldest; with i_en=0 and i_next=1 → no pop, o_count unchanged.
- Assert i_rst asynchronously with o_count=7 → o_count=0, o_empty=1, o_ready=0, o_overflow=0 immediately; next write 0x5A → o_data=0x5A.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Circular transmit FIFO between the bus write strobe and the UART transmitter.
// Head word falls through to o_data; o_ready offers it only while the transmitter requests.
module uart_tx_fifo #(
  parameter int DATA  = 8,
  parameter int DEPTH = 16
) (
  input  logic                          i_divided_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic                          i_wr_en,
  input  logic [DATA-1:0]               i_wr_data,
  input  logic                          i_next,
  input  logic                          i_clr_ovf,
  output logic [DATA-1:0]               o_data,
  output logic                          o_ready,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(DEPTH):0]        o_count,
  output logic                          o_overflow
);

  localparam int ADDR_BITS  = $clog2(DEPTH);
  localparam int COUNT_BITS = ADDR_BITS + 1;
  localparam logic [ADDR_BITS-1:0]  PTR_ONE   = ADDR_BITS'(1);
  localparam logic [COUNT_BITS-1:0] CNT_ONE   = COUNT_BITS'(1);
  localparam logic [COUNT_BITS-1:0] CNT_ZERO  = COUNT_BITS'(0);
  localparam logic [COUNT_BITS-1:0] CNT_DEPTH = COUNT_BITS'(DEPTH);

  logic [DATA-1:0]       mem_r [DEPTH];
  logic [ADDR_BITS-1:0]  wr_ptr_r;
  logic [ADDR_BITS-1:0]  rd_ptr_r;
  logic [COUNT_BITS-1:0] count_r;
  logic [COUNT_BITS-1:0] count_next_s;
  logic                  full_r;
  logic                  empty_r;
  logic                  overflow_r;
  logic                  push_s;
  logic                  pop_s;
  logic                  drop_s;

  // Full is judged before the edge, so a same-edge pop never rescues a write into a full FIFO.
  assign push_s = i_wr_en & ~full_r;
  assign drop_s = i_wr_en & full_r;
  assign pop_s  = i_en & i_next & ~empty_r;

  // Occupancy after this edge
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, occupancy, status flags and the sticky overflow
  always_ff @(posedge i_divided_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_r   <= {ADDR_BITS{1'b0}};
      rd_ptr_r   <= {ADDR_BITS{1'b0}};
      count_r    <= CNT_ZERO;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_DEPTH);
      empty_r <= (count_next_s == CNT_ZERO);
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (i_clr_ovf) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Storage is deliberately not reset; stale contents are masked by the empty flag.
  always_ff @(posedge i_divided_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= i_wr_data;
    end
  end

  assign o_data     = empty_r ? {DATA{1'b0}} : mem_r[rd_ptr_r];
  assign o_ready    = i_next & ~empty_r;
  assign o_full     = full_r;
  assign o_empty    = empty_r;
  assign o_count    = count_r;
  assign o_overflow = overflow_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue scoreboard model plus vector table and corner sequences.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_en;
  logic       i_wr_en;
  logic [7:0] i_wr_data;
  logic       i_next;
  logic       i_clr_ovf;
  logic [7:0] o_data;
  logic       o_ready;
  logic       o_full;
  logic       o_empty;
  logic [4:0] o_count;
  logic       o_overflow;

  uart_tx_fifo #(.DATA(8), .DEPTH(DEPTH)) dut (
    .i_divided_clk(clk),
    .i_rst(i_rst),
    .i_en(i_en),
    .i_wr_en(i_wr_en),
    .i_wr_data(i_wr_data),
    .i_next(i_next),
    .i_clr_ovf(i_clr_ovf),
    .o_data(o_data),
    .o_ready(o_ready),
    .o_full(o_full),
    .o_empty(o_empty),
    .o_count(o_count),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       popped;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       nx;
    logic       en;
    int         cnt;
    logic       empty;
    logic       ready;
    logic [7:0] data;
  } vec_t;
  vec_t vecs[3];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state();
    check("count", int'(o_count), q.size());
    check("empty", int'(o_empty), int'(q.size() == 0));
    check("full", int'(o_full), int'(q.size() == DEPTH));
    check("overflow", int'(o_overflow), int'(m_ovf));
    check("data", int'(o_data), (q.size() != 0) ? int'(q[0]) : 0);
    check("ready", int'(o_ready), int'(i_next && q.size() != 0));
  endtask

  // Drives one cycle starting at a falling edge; the model decides pop/push/drop before the edge.
  task automatic cycle(input logic wr, input logic [7:0] d, input logic nx,
                       input logic en, input logic clr, output logic did_pop);
    logic full_pre;
    logic exp_ready;
    i_wr_en = wr; i_wr_data = d; i_next = nx; i_en = en; i_clr_ovf = clr;
    #1;
    exp_ready = nx && (q.size() != 0);
    check("ready_pre", int'(o_ready), int'(exp_ready));
    did_pop  = en && exp_ready;
    full_pre = (q.size() == DEPTH);
    if (did_pop) begin
      check("pop_data", int'(o_data), int'(q[0]));
      void'(q.pop_front());
    end
    if (wr && !full_pre) q.push_back(d);
    if (wr && full_pre) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  task automatic drain();
    int budget = 40;
    while (q.size() != 0 && budget > 0) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, popped);
      budget--;
    end
    check("drain_done", q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{wr: 1'b1, d: 8'hA5, nx: 1'b0, en: 1'b1, cnt: 1, empty: 1'b0, ready: 1'b0, data: 8'hA5};
    vecs[1] = '{wr: 1'b0, d: 8'h00, nx: 1'b1, en: 1'b0, cnt: 1, empty: 1'b0, ready: 1'b1, data: 8'hA5};
    vecs[2] = '{wr: 1'b0, d: 8'h00, nx: 1'b1, en: 1'b1, cnt: 0, empty: 1'b1, ready: 1'b0, data: 8'h00};

    i_rst = 1'b1; i_en = 1'b1; i_wr_en = 1'b0; i_wr_data = 8'h00; i_next = 1'b1; i_clr_ovf = 1'b0;
    #1;
    check_state();
    @(negedge clk);
    i_rst = 1'b0;

    // Vector table: single word through the handshake
    for (int i = 0; i < 3; i++) begin
      cycle(vecs[i].wr, vecs[i].d, vecs[i].nx, vecs[i].en, 1'b0, popped);
      check("vec_count", int'(o_count), vecs[i].cnt);
      check("vec_empty", int'(o_empty), int'(vecs[i].empty));
      check("vec_ready", int'(o_ready), int'(vecs[i].ready));
      check("vec_data", int'(o_data), int'(vecs[i].data));
    end

    // Fill to full, then dropped writes and overflow set/clear priority
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b1, 1'b0, popped);
    check("full_flag", int'(o_full), 1);
    check("full_count", int'(o_count), 16);
    cycle(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, popped);
    check("ovf_set", int'(o_overflow), 1);
    cycle(1'b1, 8'hFE, 1'b0, 1'b1, 1'b1, popped);
    check("ovf_set_wins", int'(o_overflow), 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, popped);
    check("ovf_clear", int'(o_overflow), 0);
    cycle(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, popped);
    check("drop_with_pop_count", int'(o_count), 15);
    check("drop_with_pop_ovf", int'(o_overflow), 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, popped);
    drain();

    // Transmitter model: requests while idle, busy for 3 cycles after each latch
    begin
      int busy = 0;
      int latches = 0;
      logic [7:0] wdata[3];
      wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33;
      for (int c = 0; c < 30; c++) begin
        cycle(c < 3, (c < 3) ? wdata[c] : 8'h00, busy == 0, 1'b1, 1'b0, popped);
        if (popped) begin
          latches++;
          busy = 3;
        end else if (busy > 0) begin
          busy--;
        end
      end
      check("tx_latches", latches, 3);
      check("tx_end_empty", int'(o_empty), 1);
    end

    // Pointer wrap-around
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b1, 1'b0, popped);
    drain();
    for (int i = 0; i < 12; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b1, 1'b0, popped);
    check("wrap_peak", int'(o_count), 12);
    drain();

    // Simultaneous push and pop at count 5, and read-side freeze
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b1, 1'b0, popped);
    cycle(1'b1, 8'h77, 1'b1, 1'b1, 1'b0, popped);
    check("simul_count", int'(o_count), 5);
    check("simul_popped", int'(popped), 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, popped);
    check("freeze_count", int'(o_count), 5);
    cycle(1'b1, 8'h78, 1'b1, 1'b0, 1'b0, popped);
    check("freeze_write", int'(o_count), 6);
    drain();

    // Asynchronous reset mid-cycle with count 7 and overflow set
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b1, 1'b0, popped);
    cycle(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, popped);
    for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, popped);
    i_next = 1'b1; i_en = 1'b0;
    #1;
    check("pre_rst_count", int'(o_count), 7);
    check("pre_rst_ovf", int'(o_overflow), 1);
    #1;
    i_rst = 1'b1;
    #1;
    q.delete();
    m_ovf = 1'b0;
    check_state();
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    cycle(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, popped);
    check("post_rst_data", int'(o_data), 8'h5A);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
